// File: rtl/fp_sqrt_sequencer.sv
// fp_sqrt_sequencer: multi-cycle unsigned Q16.16 square root using Newton-Raphson
// iteration x <- (x + a/x)/2, with each quotient obtained from an external shared
// divider over a valid/ready request and a single-cycle response strobe.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_a      operand handshake (in_ready high only when idle)
//   out_valid/out_ready/out_root result handshake (held until accepted)
//   div_req_valid/div_req_ready request handshake; div_num = a, div_den = x
//   div_rsp_valid/div_quot      quotient strobe (no backpressure), sampled in DIV_WAIT
//   busy                        high whenever not idle
//
// Build option: FP_SQRT_EARLY_EXIT_EN -- finish as soon as an update leaves x
// unchanged instead of always running NUM_ITER iterations.

module fp_sqrt_sequencer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FRAC_BITS  = 16,
   parameter int unsigned NUM_ITER   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_a,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_root,
   output logic                  div_req_valid,
   input  logic                  div_req_ready,
   output logic [DATA_WIDTH-1:0] div_num,
   output logic [DATA_WIDTH-1:0] div_den,
   input  logic                  div_rsp_valid,
   input  logic [DATA_WIDTH-1:0] div_quot,
   output logic                  busy
);

   localparam int unsigned CNT_W = 4;
   localparam logic [DATA_WIDTH-1:0] FP_ONE = DATA_WIDTH'(1) << FRAC_BITS;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_INIT     = 3'd1,
      S_DIV_REQ  = 3'd2,
      S_DIV_WAIT = 3'd3,
      S_UPDATE   = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   state_t state_q, state_d;

   logic [DATA_WIDTH-1:0] a_q, x_q, q_q;
   logic [CNT_W-1:0]      cnt_q;

   logic                  in_ready_d, out_valid_d, div_req_valid_d, busy_d;

   logic [DATA_WIDTH:0]   sum;
   logic [DATA_WIDTH-1:0] x_upd, x_half;
   logic [CNT_W-1:0]      cnt_inc;
   logic                  last_iter, finish;

   // Update arithmetic: one extra sum bit so (x + q) never overflows
   assign sum       = {1'b0, x_q} + {1'b0, q_q};
   assign x_upd     = DATA_WIDTH'(sum >> 1);
   assign x_half    = a_q >> 1;
   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign last_iter = (cnt_inc == CNT_W'(NUM_ITER));

`ifdef FP_SQRT_EARLY_EXIT_EN
   assign finish = last_iter || (x_upd == x_q);
`else
   assign finish = last_iter;
`endif

   // State register and registered handshake/status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         in_ready      <= 1'b1;
         out_valid     <= 1'b0;
         div_req_valid <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state_q       <= state_d;
         in_ready      <= in_ready_d;
         out_valid     <= out_valid_d;
         div_req_valid <= div_req_valid_d;
         busy          <= busy_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (in_valid && in_ready) state_d = S_INIT;
         S_INIT:     state_d = (a_q == '0) ? S_DONE : S_DIV_REQ;
         S_DIV_REQ:  if (div_req_ready) state_d = S_DIV_WAIT;
         S_DIV_WAIT: if (div_rsp_valid) state_d = S_UPDATE;
         S_UPDATE:   state_d = finish ? S_DONE : S_DIV_REQ;
         S_DONE:     if (out_ready) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Output decode from the next state so the outputs come straight off flops
   always_comb begin
      in_ready_d      = 1'b0;
      out_valid_d     = 1'b0;
      div_req_valid_d = 1'b0;
      busy_d          = 1'b1;
      case (state_d)
         S_IDLE: begin
            in_ready_d = 1'b1;
            busy_d     = 1'b0;
         end
         S_DIV_REQ: div_req_valid_d = 1'b1;
         S_DONE:    out_valid_d     = 1'b1;
         default:   ;
      endcase
   end

   // Datapath: latched radicand, estimate x, quotient q, iteration count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         x_q   <= '0;
         q_q   <= '0;
         cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (in_valid && in_ready) a_q <= in_a;
            S_INIT: begin
               cnt_q <= '0;
               if (a_q == '0)
                  x_q <= '0;
               else if (x_half == '0)
                  x_q <= FP_ONE;
               else
                  x_q <= x_half;
            end
            S_DIV_WAIT: if (div_rsp_valid) q_q <= div_quot;
            S_UPDATE: begin
               x_q   <= x_upd;
               cnt_q <= cnt_inc;
            end
            default: ;
         endcase
      end
   end

   // x doubles as the divisor while iterating and as the result once done
   assign div_num  = a_q;
   assign div_den  = x_q;
   assign out_root = x_q;

endmodule

// File: tb/tb_fp_sqrt_sequencer.sv
// Testbench for fp_sqrt_sequencer: behavioural divider with programmable
// response delay and request stall, expected results queued at stimulus time
// and compared when the result handshake appears.

module tb_fp_sqrt_sequencer;

   localparam int unsigned DW = 32;
   localparam int unsigned NI = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_a;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_root;
   logic          div_req_valid;
   logic          div_req_ready;
   logic [DW-1:0] div_num;
   logic [DW-1:0] div_den;
   logic          div_rsp_valid;
   logic [DW-1:0] div_quot;
   logic          busy;

   fp_sqrt_sequencer #(.DATA_WIDTH(DW), .FRAC_BITS(16), .NUM_ITER(NI)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
      .out_valid(out_valid), .out_ready(out_ready), .out_root(out_root),
      .div_req_valid(div_req_valid), .div_req_ready(div_req_ready),
      .div_num(div_num), .div_den(div_den),
      .div_rsp_valid(div_rsp_valid), .div_quot(div_quot),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Truncating Q16.16 divide, saturating on a zero divisor
   function automatic logic [31:0] divq(input logic [31:0] n, input logic [31:0] d);
      logic [63:0] t;
      if (d == 32'd0) return 32'hFFFF_FFFF;
      t = ({32'd0, n} << 16) / {32'd0, d};
      return t[31:0];
   endfunction

   // Reference Newton-Raphson sequence
   function automatic void model(input logic [31:0] a, output logic [31:0] root, output int iters);
      logic [31:0] x, q, xn;
      logic [32:0] s;
      iters = 0;
      if (a == 32'd0) begin
         root = 32'd0;
         return;
      end
      x = a >> 1;
      if (x == 32'd0) x = 32'h0001_0000;
      for (int i = 0; i < int'(NI); i++) begin
         q = divq(a, x);
         s = {1'b0, x} + {1'b0, q};
         xn = s[32:1];
         iters++;
`ifdef FP_SQRT_EARLY_EXIT_EN
         if (xn == x) begin
            x = xn;
            break;
         end
`endif
         x = xn;
      end
      root = x;
   endfunction

   typedef struct {
      logic [31:0] root;
      int          lat;
      int          reqs;
   } exp_t;
   exp_t sb[$];

   // Divider/handshake environment knobs
   int dly    = 1;
   int stall  = 0;
   int stall_left = 0;
   bit div_en = 1'b1;

   // Request monitor
   int          req_cnt = 0;
   logic [31:0] den_log[$];
   logic [31:0] hold_num, hold_den;
   logic        prev_v = 1'b0;

   logic [31:0] last_root;
   int          last_reqs;

   // Divider request ready: low for 'stall' cycles at the start of each request
   initial begin
      div_req_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (div_req_valid) begin
            if (stall_left > 0) begin
               div_req_ready = 1'b0;
               stall_left--;
            end else begin
               div_req_ready = 1'b1;
            end
         end else begin
            div_req_ready = 1'b0;
            stall_left    = stall;
         end
      end
   end

   // Divider: quotient strobe 'dly' cycles after the request handshake
   initial begin
      logic [31:0] dn, dd;
      int          dl;
      div_rsp_valid = 1'b0;
      div_quot      = '0;
      forever begin
         @(negedge clk);
         if (rst_n && div_req_valid && div_req_ready) begin
            dn = div_num;
            dd = div_den;
            dl = dly;
            @(posedge clk);
            repeat (dl - 1) @(posedge clk);
            #1;
            if (div_en) begin
               div_rsp_valid = 1'b1;
               div_quot      = divq(dn, dd);
               @(posedge clk);
               #1;
               div_rsp_valid = 1'b0;
            end
         end
      end
   end

   // Count requests, log divisors, and require stable operands while stalled
   initial begin
      forever begin
         @(negedge clk);
         if (div_req_valid) begin
            if (!prev_v) begin
               hold_num = div_num;
               hold_den = div_den;
               den_log.push_back(div_den);
               req_cnt++;
            end else begin
               check_eq("req_num_hold", 64'(div_num), 64'(hold_num));
               check_eq("req_den_hold", 64'(div_den), 64'(hold_den));
            end
         end
         prev_v = div_req_valid;
      end
   end

   task automatic run_op(input logic [31:0] a, input int d, input int st, input int hold);
      exp_t        e, p;
      logic [31:0] r;
      int          it, t0, lat;
      bit          got;
      model(a, r, it);
      e.root = r;
      e.reqs = it;
      e.lat  = (a == 32'd0) ? 2 : 2 + it * (d + 2) + it * st;
      sb.push_back(e);
      dly   = d;
      stall = st;
      req_cnt = 0;
      den_log.delete();
      @(posedge clk);
      #1;
      check_eq("in_ready_idle", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_a     = a;
      t0       = cyc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (out_valid) begin
            got = 1'b1;
            break;
         end
      end
      p = sb.pop_front();
      if (!got) begin
         check_eq("out_timeout", 64'd0, 64'd1);
         return;
      end
      lat = cyc - t0;
      last_root = out_root;
      last_reqs = req_cnt;
      check_eq("root_model", 64'(out_root), 64'(p.root));
      check_eq("latency", 64'(lat), 64'(p.lat));
      check_eq("req_count", 64'(req_cnt), 64'(p.reqs));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq("out_valid_hold", 64'(out_valid), 64'd1);
         check_eq("out_root_hold", 64'(out_root), 64'(last_root));
         check_eq("in_ready_hold", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check_eq("in_ready_after", 64'(in_ready), 64'd1);
      check_eq("out_valid_after", 64'(out_valid), 64'd0);
      check_eq("busy_after", 64'(busy), 64'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check_eq({tag, "_out_root"}, 64'(out_root), 64'd0);
      check_eq({tag, "_req_valid"}, 64'(div_req_valid), 64'd0);
      check_eq({tag, "_div_num"}, 64'(div_num), 64'd0);
      check_eq({tag, "_div_den"}, 64'(div_den), 64'd0);
      check_eq({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      logic [31:0] ra, diff;
      bit          bad, seen;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Zero radicand: immediate result, no divider traffic
      run_op(32'h0000_0000, 1, 0, 0);
      check_eq("zero_root", 64'(last_root), 64'd0);
      check_eq("zero_reqs", 64'(last_reqs), 64'd0);

      // Perfect square 4.0
      run_op(32'h0004_0000, 1, 0, 0);
      check_eq("sq4_root", 64'(last_root), 64'h0002_0000);
`ifdef FP_SQRT_EARLY_EXIT_EN
      check_eq("sq4_reqs", 64'(last_reqs), 64'd1);
`else
      check_eq("sq4_reqs", 64'(last_reqs), 64'd4);
`endif

      // Tiny radicand: initial estimate substituted with 1.0
      run_op(32'h0000_0001, 3, 0, 0);
      check_eq("tiny_den0", 64'(den_log.size() > 0 ? den_log[0] : 32'd0), 64'h0001_0000);

      // Non-square 2.0: divisor sequence and final value
      run_op(32'h0002_0000, 1, 0, 0);
      check_eq("two_den0", 64'(den_log.size() > 0 ? den_log[0] : 32'd0), 64'h0001_0000);
      check_eq("two_den1", 64'(den_log.size() > 1 ? den_log[1] : 32'd0), 64'h0001_8000);
      check_eq("two_den2", 64'(den_log.size() > 2 ? den_log[2] : 32'd0), 64'h0001_6AAA);
      diff = (last_root > 32'h0001_6A09) ? last_root - 32'h0001_6A09 : 32'h0001_6A09 - last_root;
      check_eq("two_within_lsb", 64'(diff <= 32'd1), 64'd1);

      // Request backpressure, then result backpressure
      run_op(32'h0002_0000, 1, 5, 0);
      run_op(32'h0004_0000, 2, 0, 3);

      // Back-to-back and random operands
      for (int i = 0; i < 4; i++) begin
         ra = $urandom();
         run_op(ra, int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end
      run_op(32'hFFFF_FFFF, 1, 0, 0);

      // Reset while waiting on the divider, then a stray response
      div_en = 1'b0;
      dly    = 1;
      stall  = 0;
      req_cnt = 0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_a     = 32'h0009_0000;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_cnt > 0 && !div_req_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq("reach_div_wait", 64'(seen && busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check_reset_values("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      div_rsp_valid = 1'b1;
      div_quot      = 32'h0001_2345;
      @(posedge clk);
      #1;
      div_rsp_valid = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid || busy || !in_ready || div_req_valid) bad = 1'b1;
      end
      check_eq("post_rst_idle", 64'(bad), 64'd0);
      div_en = 1'b1;

      run_op(32'h0009_0000, 1, 0, 0);
      check_eq("sq9_root", 64'(last_root), 64'h0003_0000);

      if (sb.size() != 0) check_eq("sb_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      check_eq("global_timeout", 64'd0, 64'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_sqrt_sequencer.md
# fp_sqrt_sequencer

Multi-cycle Q16.16 unsigned square-root controller. It runs Newton-Raphson iteration x ← (x + a/x)/2 by issuing division requests to an external, shared iterative fixed-point divider over a valid/ready handshake. Only the add and shift are done locally. It sits beside the EKF matrix datapath and serves covariance/innovation normalisation, replacing the unrolled combinational square root in synthesised paths.

## Interface
- DATA_WIDTH, 32, operand/result width (Q format total bits)
- FRAC_BITS, 16, fractional bits; FP_ONE = 1 << FRAC_BITS
- NUM_ITER, 4, Newton-Raphson iterations (1..15)
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  operand valid
- in_ready  out  1  high only in IDLE
- in_a  in  DATA_WIDTH  radicand, unsigned Q16.16
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- out_root  out  DATA_WIDTH  square root, unsigned Q16.16
- div_req_valid  out  1  division request valid
- div_req_ready  in  1  divider accepts request
- div_num  out  DATA_WIDTH  dividend (= latched a)
- div_den  out  DATA_WIDTH  divisor (= current x)
- div_rsp_valid  in  1  single-cycle quotient strobe, no backpressure
- div_quot  in  DATA_WIDTH  quotient num/den, Q16.16, truncated
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, INIT, DIV_REQ, DIV_WAIT, UPDATE, DONE.
- IDLE: in_ready=1. On in_valid & in_ready, latch in_a and go to INIT.
- INIT:
  - If a==0: root=0, go to DONE. No divider traffic.
  - Else x = a>>1. If that is 0, x = FP_ONE. Clear iteration count. Go to DIV_REQ.
- DIV_REQ: div_req_valid=1. div_num/div_den are stable from assertion until handshake. On div_req_valid & div_req_ready, go to DIV_WAIT.
- DIV_WAIT: wait for div_rsp_valid, latch div_quot into q, go to UPDATE.
- UPDATE:
  - x = (x + q) >> 1. The sum is computed in DATA_WIDTH+1 bits, so there is no overflow for a up to 0xFFFF_FFFF.
  - Increment the count. If count == NUM_ITER, go to DONE; else go to DIV_REQ.
- DONE: out_valid=1 and out_root=x, both stable. On out_ready, go to IDLE.
- div_rsp_valid outside DIV_WAIT is ignored. in_valid outside IDLE is not accepted.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_root=0, div_req_valid=0, div_num=0, div_den=0, busy=0.
- Reset mid-operation aborts immediately to IDLE. Any response arriving after reset is ignored.

## Timing
- Input accepted in cycle T; INIT in T+1; first DIV_REQ in T+2.
- Divider model used for timing: it answers D cycles (D≥1) after the request handshake.
- Per iteration, with div_req_ready high, the cost is D+2 cycles: 1 request, D wait, 1 update.
- out_valid first high in cycle T+2+NUM_ITER·(D+2). Example: D=1, NUM_ITER=4 gives T+14.
- a==0: out_valid in T+2.
- Each cycle of div_req_ready low adds exactly one cycle.
- Back-to-back throughput: a new operand can be accepted the cycle after the out handshake. in_ready is registered from state.

## Configuration
- FP_SQRT_EARLY_EXIT_EN defined:
  - In UPDATE, if the new x equals the previous x (converged), go to DONE regardless of the iteration count.
  - Latency shrinks by (D+2) per skipped iteration.
- Undefined: always exactly NUM_ITER iterations, so latency is deterministic.

## Test plan
- Zero input: in_a=0x0000_0000 -> out_root=0 with out_valid at T+2; div_req_valid never asserted.
- Perfect square: in_a=0x0004_0000 (4.0), D=1, ready high.
  - out_root=0x0002_0000.
  - Exactly 4 requests without FP_SQRT_EARLY_EXIT_EN, out_valid at T+14.
  - 1 request with the macro, out_valid at T+5.
- Tiny input: in_a=0x0000_0001 -> first div_den=0x0001_0000 (FP_ONE substitution). Result matches the bit-exact truncating reference model.
- Non-square: in_a=0x0002_0000 (2.0):
  - Successive div_den values are 0x0001_0000, 0x0001_8000, 0x0001_6AAA, ….
  - Final out_root bit-exact to the model, within 1 LSB of 0x0001_6A09.
- Backpressure:
  - div_req_ready low for 5 cycles -> div_num/div_den held constant and total latency +5 per stalled request.
  - out_ready low for 3 cycles -> out_valid/out_root held and in_ready stays 0.
- Reset mid-op: assert rst_n=0 during DIV_WAIT, release, then pulse div_rsp_valid -> all outputs at reset values, no out_valid. A following in_a=0x0009_0000 yields 0x0003_0000.
